// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - icache, dcache and main-memory signal bundle for mem_arbiter
//
// Signals (slave = arbiter view):
//   i_read/i_address        in   icache block-read request and block address
//   i_readinst/i_busywait   out  refilled 4-word block, icache stall
//   d_read/d_write          in   dcache block read / write request (mutually exclusive)
//   d_address/d_writedata   in   dcache block address and write word
//   d_readdata/d_busywait   out  dcache read word, dcache stall
//   mem_read/mem_write      out  memory strobes
//   mem_address             out  9-bit memory word address
//   mem_writedata           out  memory write word
//   mem_readdata            in   memory read word
//   mem_busywait            in   memory stall
interface mem_arbiter_if;
  logic         i_read;
  logic [5:0]   i_address;
  logic [127:0] i_readinst;
  logic         i_busywait;
  logic         d_read;
  logic         d_write;
  logic [5:0]   d_address;
  logic [31:0]  d_writedata;
  logic [31:0]  d_readdata;
  logic         d_busywait;
  logic         mem_read;
  logic         mem_write;
  logic [8:0]   mem_address;
  logic [31:0]  mem_writedata;
  logic [31:0]  mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  i_read, i_address,
    output i_readinst, i_busywait,
    input  d_read, d_write, d_address, d_writedata,
    output d_readdata, d_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport master (
    output i_read, i_address,
    input  i_readinst, i_busywait,
    output d_read, d_write, d_address, d_writedata,
    input  d_readdata, d_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one word-wide main memory between the icache and dcache
//
// An instruction block refill becomes four single-word read beats with a one-cycle
// gap between beats; a data access is forwarded as a single word read or write.
// Simultaneous requests alternate, starting with the icache after reset.
//
// Ports:
//   clk    system clock, all state changes on posedge
//   reset  synchronous active-high reset
//   bus    mem_arbiter_if.slave (cache and memory handshakes)
module mem_arbiter (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_I_REQ,
    S_I_GAP,
    S_I_RESP,
    S_D_REQ,
    S_D_RESP
  } state_t;

  state_t       state, state_nx;
  logic [1:0]   beat;
  logic         issued;
  logic         last_grant_i;   // 1: the icache won the most recent collision
  logic [5:0]   i_addr_q;
  logic [5:0]   d_addr_q;
  logic         d_write_q;
  logic [31:0]  d_wdata_q;
  logic [127:0] i_readinst_q;
  logic [31:0]  d_readdata_q;

  logic         i_pend, d_pend, grant_i, grant_d, beat_done;
  logic         mem_read, mem_write;
  logic [8:0]   mem_address;
  logic [31:0]  mem_writedata;

  assign i_pend    = bus.i_read;
  assign d_pend    = bus.d_read | bus.d_write;
  // On a collision the side that did not win the previous collision is served.
  assign grant_i   = i_pend & (~d_pend | ~last_grant_i);
  assign grant_d   = d_pend & ~grant_i;
  // The edge that raises issued can never complete the beat, so the memory
  // always sees the strobe for at least one full cycle first.
  assign beat_done = issued & ~bus.mem_busywait;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      S_IDLE: begin
        if (grant_i)      state_nx = S_I_REQ;
        else if (grant_d) state_nx = S_D_REQ;
      end
      S_I_REQ: begin
        mem_read    = 1'b1;
        mem_address = {1'b0, i_addr_q, beat};
        if (beat_done) state_nx = (beat == 2'd3) ? S_I_RESP : S_I_GAP;
      end
      S_I_GAP:  state_nx = S_I_REQ;
      S_D_REQ: begin
        mem_read      = ~d_write_q;
        mem_write     = d_write_q;
        mem_address   = {3'b100, d_addr_q};
        mem_writedata = d_write_q ? d_wdata_q : 32'd0;
        if (beat_done) state_nx = S_D_RESP;
      end
      S_I_RESP: state_nx = S_IDLE;
      S_D_RESP: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Request fields are latched at grant so a requester that drops or changes
  // its inputs mid-service cannot disturb the running beat or burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat         <= 2'd0;
      issued       <= 1'b0;
      last_grant_i <= 1'b0;
      i_addr_q     <= '0;
      d_addr_q     <= '0;
      d_write_q    <= 1'b0;
      d_wdata_q    <= '0;
      i_readinst_q <= '0;
      d_readdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          beat   <= 2'd0;
          issued <= 1'b0;
          if (grant_i) i_addr_q <= bus.i_address;
          if (grant_d) begin
            d_addr_q  <= bus.d_address;
            d_write_q <= bus.d_write;
            d_wdata_q <= bus.d_writedata;
          end
          if (i_pend && d_pend) last_grant_i <= grant_i;
        end
        S_I_REQ: begin
          if (!issued) begin
            issued <= 1'b1;
          end else if (!bus.mem_busywait) begin
            issued <= 1'b0;
            i_readinst_q[{beat, 5'd0} +: 32] <= bus.mem_readdata;
            beat <= beat + 2'd1;
          end
        end
        S_D_REQ: begin
          if (!issued) begin
            issued <= 1'b1;
          end else if (!bus.mem_busywait) begin
            issued <= 1'b0;
            if (!d_write_q) d_readdata_q <= bus.mem_readdata;
          end
        end
        default: issued <= 1'b0;
      endcase
    end
  end

  assign bus.i_readinst    = i_readinst_q;
  assign bus.d_readdata    = d_readdata_q;
  assign bus.i_busywait    = bus.i_read && (state != S_I_RESP);
  assign bus.d_busywait    = (bus.d_read || bus.d_write) && (state != S_D_RESP);
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.mem_address   = mem_address;
  assign bus.mem_writedata = mem_writedata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level reference
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory: holds each strobe for mem_b cycles per beat. Unwritten words read as address ^ salt.
  int          mem_b = 3;
  logic [31:0] salt = 32'd0;
  int          cnt = 0;
  bit          mem_written [512];
  logic [31:0] mem_data [512];
  wire         strobe = bus.mem_read | bus.mem_write;

  assign bus.mem_readdata = mem_written[bus.mem_address] ? mem_data[bus.mem_address]
                                                         : ({23'd0, bus.mem_address} ^ salt);
  assign bus.mem_busywait = strobe && (cnt != mem_b - 1);

  always @(posedge clk) begin
    if (!strobe) begin
      cnt <= 0;
    end else if (cnt == mem_b - 1) begin
      cnt <= 0;
      if (bus.mem_write) begin
        mem_written[bus.mem_address] <= 1'b1;
        mem_data[bus.mem_address]    <= bus.mem_writedata;
      end
    end else begin
      cnt <= cnt + 1;
    end
  end

  // Reference state
  bit          ref_written [512];
  logic [31:0] ref_data [512];
  bit          lg_i = 1'b0;
  logic [31:0] exp_dread = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [8:0] a);
    return ref_written[a] ? ref_data[a] : ({23'd0, a} ^ salt);
  endfunction

  // Runs one I and/or D miss, each raised at its start cycle and dropped when its
  // busywait falls. Expected RESP cycles come from a service-order model: a request
  // is granted at max(arrival, cycle after the previous RESP) and lasts 4B+4 (I) or B+1 (D).
  task automatic run_pair(input bit do_i, input logic [5:0] ia, input int si,
                          input bit do_d, input bit dw, input logic [5:0] da,
                          input logic [31:0] wd, input int sd,
                          output logic [127:0] i_got, output logic [31:0] d_got);
    int len_i, len_d, ei, ed, t;
    int i_hi, d_hi, i_st, d_st;
    bit i_act, d_act, i_fin, d_fin;
    logic [127:0] i_exp;
    logic [31:0]  d_exp;
    logic [8:0]   dadr;
    len_i = 4 * mem_b + 4;
    len_d = mem_b + 1;
    dadr  = {3'b100, da};
    ei = 0;
    ed = 0;
    if (do_i && !do_d) begin
      ei = si + len_i;
    end else if (do_d && !do_i) begin
      ed = sd + len_d;
    end else if (do_i && do_d) begin
      if (si < sd || (si == sd && !lg_i)) begin
        if (si == sd) lg_i = 1'b1;
        ei = si + len_i;
        t  = (ei + 1 > sd) ? ei + 1 : sd;
        ed = t + len_d;
      end else begin
        if (si == sd) lg_i = 1'b0;
        ed = sd + len_d;
        t  = (ed + 1 > si) ? ed + 1 : si;
        ei = t + len_i;
      end
    end
    i_exp = {ref_word({1'b0, ia, 2'd3}), ref_word({1'b0, ia, 2'd2}),
             ref_word({1'b0, ia, 2'd1}), ref_word({1'b0, ia, 2'd0})};
    d_exp = dw ? exp_dread : ref_word(dadr);

    i_hi = 0; d_hi = 0; i_st = 0; d_st = 0;
    i_act = 1'b0; d_act = 1'b0; i_fin = !do_i; d_fin = !do_d;
    i_got = '0; d_got = '0;
    for (int c = 0; c < 400 && !(i_fin && d_fin); c++) begin
      @(negedge clk);
      if (do_i && c == si) begin
        bus.i_read = 1'b1; bus.i_address = ia; i_act = 1'b1;
      end
      if (do_d && c == sd) begin
        bus.d_read = !dw; bus.d_write = dw; bus.d_address = da; bus.d_writedata = wd; d_act = 1'b1;
      end
      #1;
      if (strobe) begin
        if (bus.mem_address[8]) d_st++;
        else                    i_st++;
      end
      if (i_act) begin
        if (bus.i_busywait) i_hi++;
        else begin
          i_act = 1'b0; i_fin = 1'b1; i_got = bus.i_readinst; bus.i_read = 1'b0;
        end
      end
      if (d_act) begin
        if (bus.d_busywait) d_hi++;
        else begin
          d_act = 1'b0; d_fin = 1'b1; d_got = bus.d_readdata;
          bus.d_read = 1'b0; bus.d_write = 1'b0;
        end
      end
    end
    check("completion_timeout", {127'd0, i_fin && d_fin}, 128'd1);
    if (do_i) begin
      check("i_busy_cycles", 128'(i_hi), 128'(ei - si));
      check("i_block", i_got, i_exp);
      check("i_strobe_cycles", 128'(i_st), 128'(4 * mem_b));
    end
    if (do_d) begin
      check("d_busy_cycles", 128'(d_hi), 128'(ed - sd));
      check("d_readdata", {96'd0, d_got}, {96'd0, d_exp});
      check("d_strobe_cycles", 128'(d_st), 128'(mem_b));
      if (dw) begin
        ref_written[dadr] = 1'b1;
        ref_data[dadr]    = wd;
        check("mem_write_word", {96'd0, mem_data[dadr]}, {96'd0, wd});
        check("mem_write_flag", {127'd0, mem_written[dadr]}, 128'd1);
      end else begin
        exp_dread = d_exp;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] ig;
    logic [31:0]  dg;
    logic [5:0]   ra;

    bus.i_read = 1'b1; bus.i_address = 6'd0;
    bus.d_read = 1'b1; bus.d_write = 1'b0; bus.d_address = 6'd0; bus.d_writedata = 32'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_mem_read", {127'd0, bus.mem_read}, 128'd0);
    check("rst_mem_write", {127'd0, bus.mem_write}, 128'd0);
    check("rst_mem_address", {119'd0, bus.mem_address}, 128'd0);
    check("rst_mem_writedata", {96'd0, bus.mem_writedata}, 128'd0);
    check("rst_i_readinst", bus.i_readinst, 128'd0);
    check("rst_d_readdata", {96'd0, bus.d_readdata}, 128'd0);
    check("rst_i_busywait_req", {127'd0, bus.i_busywait}, 128'd1);
    check("rst_d_busywait_req", {127'd0, bus.d_busywait}, 128'd1);
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    #1;
    check("rst_i_busywait_idle", {127'd0, bus.i_busywait}, 128'd0);
    check("rst_d_busywait_idle", {127'd0, bus.d_busywait}, 128'd0);
    reset = 1'b0;

    // Collisions out of reset: icache first, then dcache first on the repeat.
    mem_b = 3;
    run_pair(1'b1, 6'h11, 0, 1'b1, 1'b0, 6'h22, 32'd0, 0, ig, dg);
    run_pair(1'b1, 6'h12, 0, 1'b1, 1'b0, 6'h23, 32'd0, 0, ig, dg);

    // Block 5 refill with B = 5 and memory data equal to the address.
    salt = 32'd0;
    mem_b = 5;
    run_pair(1'b1, 6'h05, 0, 1'b0, 1'b0, 6'h00, 32'd0, 0, ig, dg);
    check("i_block_0x05", ig, 128'h00000017_00000016_00000015_00000014);

    // Single data write.
    run_pair(1'b0, 6'h00, 0, 1'b1, 1'b1, 6'h2A, 32'hDEADBEEF, 0, ig, dg);
    check("mem_0x12a", {96'd0, mem_data[9'h12A]}, {96'd0, 32'hDEADBEEF});

    // Data read arriving in the middle of an instruction burst.
    mem_b = 4;
    run_pair(1'b1, 6'h3C, 0, 1'b1, 1'b0, 6'h07, 32'd0, 9, ig, dg);
    run_pair(1'b0, 6'h00, 0, 1'b1, 1'b0, 6'h2A, 32'd0, 0, ig, dg);
    check("d_read_back_0x12a", {96'd0, dg}, {96'd0, 32'hDEADBEEF});

    // Reset while the burst is in beat 2, then a clean restart.
    mem_b = 3;
    ra = 6'h1B;
    @(negedge clk);
    bus.i_read = 1'b1; bus.i_address = ra;
    repeat (2 * mem_b + 4) @(negedge clk);
    #1;
    check("pre_reset_addr", {119'd0, bus.mem_address}, {119'd0, 1'b0, ra, 2'd2});
    check("pre_reset_strobe", {127'd0, bus.mem_read}, 128'd1);
    reset = 1'b1;
    bus.i_read = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_mem_read", {127'd0, bus.mem_read}, 128'd0);
    check("post_reset_i_readinst", bus.i_readinst, 128'd0);
    check("post_reset_d_readdata", {96'd0, bus.d_readdata}, 128'd0);
    reset = 1'b0;
    lg_i = 1'b0;
    exp_dread = 32'd0;
    run_pair(1'b1, ra, 0, 1'b0, 1'b0, 6'h00, 32'd0, 0, ig, dg);

    // Randomized mix of lone, colliding and overlapping misses.
    for (int n = 0; n < 40; n++) begin
      int kind, off;
      bit dw;
      logic [5:0]  ia, da;
      logic [31:0] wd;
      mem_b = $urandom_range(2, 6);
      salt  = $urandom;
      kind  = $urandom_range(0, 3);
      off   = $urandom_range(1, 4 * mem_b + 6);
      dw    = 1'($urandom_range(0, 1));
      ia    = 6'($urandom);
      da    = 6'($urandom);
      wd    = $urandom;
      case (kind)
        0: run_pair(1'b1, ia, 0, 1'b0, 1'b0, da, wd, 0, ig, dg);
        1: run_pair(1'b0, ia, 0, 1'b1, dw, da, wd, 0, ig, dg);
        2: run_pair(1'b1, ia, 0, 1'b1, dw, da, wd, 0, ig, dg);
        default: begin
          if ($urandom_range(0, 1) == 1) run_pair(1'b1, ia, 0, 1'b1, dw, da, wd, off, ig, dg);
          else                           run_pair(1'b1, ia, off, 1'b1, dw, da, wd, 0, ig, dg);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
